df_multiplier_pipe: RTL and testbench
=====================================

DF_MULTIPLIER_PIPE -- requirements
Module: df_multiplier_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input/output sample width in bits (unsigned).
REQ-002 SHALL have parameter COEF_W, default 8, coefficient width; legal values 2, 4, 8, 16.
REQ-003 SHALL have parameter COEF, default 8'b00011011 (27), constant unsigned coefficient, COEF_W bits.
REQ-004 SHALL have parameter OUT_SHIFT, default 5, right shift applied to the full product before output selection.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ce, input, 1, clock enable; low freezes all pipeline registers.
REQ-008 SHALL have port in_valid, input, 1, qualifies data.
REQ-009 SHALL have port data, input, DATA_W, multiplicand sample.
REQ-010 SHALL have port out_valid, output, 1, qualifies out.
REQ-011 SHALL have port out, output, DATA_W, scaled and saturated product.
REQ-012 SHALL have port ovf, output, 1, high with out_valid when out was saturated.

Function
REQ-013 SHALL form COEF_W partial products: PP[k] = data << k if COEF bit k is 1, else 0; each PP width DATA_W+COEF_W.
REQ-014 SHALL sum partial products in a registered binary adder tree: stage 1 holds COEF_W/2 pairwise sums, each further stage halves the count until one sum remains.
REQ-015 SHALL register the final stage as the output stage: shift the full sum right by OUT_SHIFT, then saturate to DATA_W bits.
REQ-016 SHALL saturate: if the shifted value exceeds 2^DATA_W-1, out = all ones and ovf = 1; otherwise out = low DATA_W bits and ovf = 0.
REQ-017 SHALL have latency L = log2(COEF_W)+1 enabled cycles from data/in_valid sampled to out/out_valid (L = 4 at defaults).
REQ-018 SHALL carry a valid bit alongside each tree stage; out_valid equals in_valid delayed by L enabled cycles.
REQ-019 SHALL advance data and valid registers only when ce = 1; with ce = 0, all registers (out, out_valid, ovf included) hold their values.
REQ-020 SHALL accept a new sample every enabled cycle (throughput 1/cycle); back-to-back valid samples emerge in order, without gaps or duplication.
REQ-021 SHALL update data registers independent of in_valid (don't-care contents); out and ovf are meaningful only when out_valid = 1.
REQ-022 SHALL hold all intermediate sums at full width (no truncation before the output stage).

Reset
REQ-023 SHALL, when reset = 1 at a rising edge, clear every stage register, valid bit, out, out_valid, and ovf to 0, regardless of ce.
REQ-024 SHALL discard samples in flight when reset is asserted mid-operation; the first out_valid after reset release follows the first in_valid by L enabled cycles.
REQ-025 SHALL give reset priority over ce and in_valid.

Configuration
REQ-026 SHALL recognise macro DF_MULT_ROUND_EN.
REQ-027 SHALL, with DF_MULT_ROUND_EN defined and OUT_SHIFT > 0, add 2^(OUT_SHIFT-1) to the full sum before shifting (round half up), applied ahead of saturation, with no change in latency.
REQ-028 SHALL, without DF_MULT_ROUND_EN, truncate (plain right shift); ports and latency are identical in both builds.

Verification
REQ-029 SHALL cover a defaults sweep, truncate build: data = 0, 51, 102, 153, 204, 255 with in_valid = 1 and ce = 1 -> out = 0, 43, 86, 129, 172, 215 four cycles later, back-to-back; ovf = 0.
REQ-030 SHALL cover rounding: data = 1 at defaults -> out = 0 without DF_MULT_ROUND_EN, out = 1 with it; data = 255 -> 215 in both builds.
REQ-031 SHALL cover saturation: OUT_SHIFT = 0, data = 255 -> out = 255 and ovf = 1; data = 9 -> out = 243 and ovf = 0.
REQ-032 SHALL cover stall: ce = 0 for 3 cycles while 2 samples are in flight -> out, out_valid, and ovf frozen; results appear after 4 total enabled cycles, order preserved.
REQ-033 SHALL cover mid-operation reset: reset = 1 for 1 cycle with 3 valid samples in flight -> out_valid stays 0 until a new in_valid, then asserts 4 cycles later with the correct value.
REQ-034 SHALL cover widths: DATA_W = 12, COEF_W = 16, COEF = 16'hA5A5, OUT_SHIFT = 16, random data stream -> out matches the saturated (data*COEF)>>16 reference model after 5 cycles.

Source files
------------

// File: rtl/df_multiplier_pipe.sv
// Constant-coefficient multiplier built from shifted partial products, a registered
// binary adder tree and a registered shift/saturate output stage. Macro DF_MULT_ROUND_EN selects round-half-up.
module df_multiplier_pipe #(
   parameter int                DATA_W    = 8,
   parameter int                COEF_W    = 8,
   parameter logic [COEF_W-1:0] COEF      = 8'b00011011,
   parameter int                OUT_SHIFT = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out,
   output logic              ovf
);

   localparam int PW     = DATA_W + COEF_W;
   localparam int LEVELS = $clog2(COEF_W);

`ifdef DF_MULT_ROUND_EN
   localparam logic [PW:0] RND = (OUT_SHIFT > 0)
      ? ((PW+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
`else
   localparam logic [PW:0] RND = '0;
`endif

   logic [PW-1:0]     pp      [0:COEF_W-1];
   logic [PW-1:0]     node_d  [1:COEF_W-1];
   logic [PW-1:0]     node_q  [1:COEF_W-1];
   logic [LEVELS-1:0] valid_q;
   logic [PW:0]       sum_ext_d;
   logic [PW:0]       shifted_d;
   logic              sat_d;
   logic [DATA_W-1:0] out_d;
   logic [DATA_W-1:0] out_q;
   logic              ovf_q;
   logic              out_valid_q;

   genvar gi;

   for (gi = 0; gi < COEF_W; gi++) begin : g_pp
      assign pp[gi] = COEF[gi] ? (PW'(data) << gi) : '0;
   end

   // Heap-ordered tree: node n sums nodes 2n and 2n+1; indices >= COEF_W are the partial products.
   for (gi = 1; gi < COEF_W; gi++) begin : g_node
      if (2 * gi >= COEF_W) begin : g_leaf
         assign node_d[gi] = pp[2*gi-COEF_W] + pp[2*gi+1-COEF_W];
      end else begin : g_inner
         assign node_d[gi] = node_q[2*gi] + node_q[2*gi+1];
      end
   end

   // The full product never exceeds PW bits; one extra bit absorbs the rounding constant.
   assign sum_ext_d = {1'b0, node_q[1]} + RND;
   assign shifted_d = sum_ext_d >> OUT_SHIFT;
   assign sat_d     = |shifted_d[PW:DATA_W];
   assign out_d     = sat_d ? '1 : shifted_d[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < COEF_W; i++) node_q[i] <= '0;
         valid_q     <= '0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (ce) begin
         node_q     <= node_d;
         valid_q[0] <= in_valid;
         for (int i = 1; i < LEVELS; i++) valid_q[i] <= valid_q[i-1];
         out_q       <= out_d;
         ovf_q       <= sat_d;
         out_valid_q <= valid_q[LEVELS-1];
      end
   end

   assign out       = out_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_df_multiplier_pipe.sv
// Directed bench: default build sweep, stall, mid-run reset, rounding, saturation
// (OUT_SHIFT = 0 instance) and a wide 12x16 instance checked against a product model.
module tb_df_multiplier_pipe;

   logic        clk = 1'b0;
   logic        reset, ce;
   logic        va, vs, vw;
   logic [7:0]  da, ds;
   logic [11:0] dw;
   logic        ova, ovs, ovw;
   logic [7:0]  oa, os;
   logic [11:0] ow;
   logic        ofa, ofs, ofw;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   df_multiplier_pipe dut_a (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(va), .data(da),
      .out_valid(ova), .out(oa), .ovf(ofa)
   );

   df_multiplier_pipe #(.OUT_SHIFT(0)) dut_s (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(vs), .data(ds),
      .out_valid(ovs), .out(os), .ovf(ofs)
   );

   df_multiplier_pipe #(.DATA_W(12), .COEF_W(16), .COEF(16'hA5A5), .OUT_SHIFT(16)) dut_w (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(vw), .data(dw),
      .out_valid(ovw), .out(ow), .ovf(ofw)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] sweep_in  [0:5];
      int         sweep_out [0:5];
      int         exp_w     [0:31];
      int         rnd1;
      longint     prod;

      sweep_in  = '{8'd0, 8'd51, 8'd102, 8'd153, 8'd204, 8'd255};
      sweep_out = '{0, 43, 86, 129, 172, 215};
`ifdef DF_MULT_ROUND_EN
      rnd1 = 1;
`else
      rnd1 = 0;
`endif

      reset = 1'b1; ce = 1'b1;
      va = 1'b0; vs = 1'b0; vw = 1'b0;
      da = '0; ds = '0; dw = '0;
      tick();
      tick();
      check("rst_out",   oa,  0);
      check("rst_valid", ova, 0);
      check("rst_ovf",   ofa, 0);
      check("rst_wvalid", ovw, 0);
      reset = 1'b0;

      // Back-to-back sweep: latency 4, so after step t the output holds sample t-3.
      for (int t = 0; t < 10; t++) begin
         va = (t < 6);
         da = (t < 6) ? sweep_in[t] : 8'd0;
         tick();
         if (t < 3) check($sformatf("sweep_pre_valid%0d", t), ova, 0);
         else if (t < 9) begin
            check($sformatf("sweep_out%0d", t-3),   oa,  sweep_out[t-3]);
            check($sformatf("sweep_valid%0d", t-3), ova, 1);
            check($sformatf("sweep_ovf%0d", t-3),   ofa, 0);
         end else check("sweep_post_valid", ova, 0);
      end

      // Rounding at defaults: 1*27/32 and 255*27/32.
      va = 1'b1; da = 8'd1;   tick();
      da = 8'd255;            tick();
      va = 1'b0; da = 8'd0;   tick(); tick();
      check("round_one",   oa,  rnd1);
      check("round_one_v", ova, 1);
      tick();
      check("round_255",   oa,  215);

      // Saturation with OUT_SHIFT = 0: 255*27 overflows, 9*27 = 243 fits.
      vs = 1'b1; ds = 8'd255; tick();
      ds = 8'd9;              tick();
      vs = 1'b0; ds = 8'd0;   tick(); tick();
      check("sat_out",   os,  255);
      check("sat_ovf",   ofs, 1);
      check("sat_valid", ovs, 1);
      tick();
      check("nosat_out", os,  243);
      check("nosat_ovf", ofs, 0);

      // Stall: A=153 emerges, B=204 is frozen inside for three disabled cycles.
      reset = 1'b1; tick(); reset = 1'b0;
      va = 1'b1; da = 8'd153; tick();
      da = 8'd204;            tick();
      va = 1'b0; da = 8'd0;   tick(); tick();
      check("stall_a_out",   oa,  129);
      check("stall_a_valid", ova, 1);
      ce = 1'b0; va = 1'b1; da = 8'd255;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_hold_out%0d", i),   oa,  129);
         check($sformatf("stall_hold_valid%0d", i), ova, 1);
         check($sformatf("stall_hold_ovf%0d", i),   ofa, 0);
      end
      ce = 1'b1; va = 1'b0; da = 8'd0;
      tick();
      check("stall_b_out",   oa,  172);
      check("stall_b_valid", ova, 1);
      tick();
      check("stall_end_valid", ova, 0);

      // Mid-run reset with three samples in flight; ce low during reset must not block it.
      va = 1'b1;
      da = 8'd255; tick();
      da = 8'd204; tick();
      da = 8'd153; tick();
      va = 1'b0; da = 8'd0;
      reset = 1'b1; ce = 1'b0; tick();
      check("mrst_valid", ova, 0);
      check("mrst_out",   oa,  0);
      reset = 1'b0; ce = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("mrst_flush_valid%0d", i), ova, 0);
      end
      va = 1'b1; da = 8'd102; tick();
      va = 1'b0; da = 8'd0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mrst_wait_valid%0d", i), ova, 0);
         tick();
      end
      check("mrst_new_out",   oa,  86);
      check("mrst_new_valid", ova, 1);

      // Wide instance: latency 5, so after step t the output holds sample t-4.
      for (int t = 0; t < 25; t++) begin
         if (t < 20) begin
            vw = 1'b1;
            dw = 12'($urandom_range(0, 4095));
            prod = longint'(dw) * 42405 + (rnd1 != 0 ? 32768 : 0);
            prod = prod >> 16;
            exp_w[t] = (prod > 4095) ? 4095 : int'(prod);
         end else begin
            vw = 1'b0;
            dw = '0;
         end
         tick();
         if (t >= 4 && t < 24) begin
            check($sformatf("wide_out%0d", t-4),   ow,  exp_w[t-4]);
            check($sformatf("wide_valid%0d", t-4), ovw, 1);
            check($sformatf("wide_ovf%0d", t-4),   ofw, 0);
         end else if (t == 24) check("wide_post_valid", ovw, 0);
         else check($sformatf("wide_pre_valid%0d", t), ovw, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
